// File: rtl/maxpool2_relu.sv
// 2x2 max-pooling with ReLU and output saturation over three channels.
// Pixels arrive row-major, one per valid_in; each pooled result appears one cycle after its window closes.
module maxpool2_relu #(
  parameter int unsigned CONV_BIT = 14,
  parameter int unsigned OUT_BIT  = 12,
  parameter int unsigned IN_SIZE  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic signed [CONV_BIT-1:0] conv_out_1,
  input  logic signed [CONV_BIT-1:0] conv_out_2,
  input  logic signed [CONV_BIT-1:0] conv_out_3,
  output logic signed [OUT_BIT-1:0]  max_value_1,
  output logic signed [OUT_BIT-1:0]  max_value_2,
  output logic signed [OUT_BIT-1:0]  max_value_3,
  output logic                       valid_out,
  output logic                       frame_done
);

  localparam int unsigned CW       = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
  localparam int unsigned HalfSize = IN_SIZE / 2;
  localparam int unsigned HW       = (HalfSize > 1) ? $clog2(HalfSize) : 1;
  localparam int unsigned PW       = CONV_BIT - 1;
  localparam logic [31:0] SatMax   = (32'd1 << (OUT_BIT - 1)) - 32'd1;

  logic [CW-1:0]               col_q, col_d, row_q, row_d;
  logic                        last_col, last_row;
  logic [HW-1:0]               lb_idx;
  logic signed [CONV_BIT-1:0]  pix    [3];
  logic [PW-1:0]               relu   [3];
  logic [PW-1:0]               hmax   [3];
  logic [PW-1:0]               pooled [3];
  logic [OUT_BIT-1:0]          sat    [3];
  logic [PW-1:0]               hold_q [3];
  // After ReLU every value is non-negative, so the sign bit is dropped from storage.
  logic [PW-1:0]               lb_q   [3][HalfSize];
  logic [OUT_BIT-1:0]          out_q  [3];
  logic                        valid_q, done_q;

  always_comb begin
    pix[0]   = conv_out_1;
    pix[1]   = conv_out_2;
    pix[2]   = conv_out_3;
    last_col = (col_q == CW'(IN_SIZE - 1));
    last_row = (row_q == CW'(IN_SIZE - 1));
    lb_idx   = HW'(col_q >> 1);
    for (int ch = 0; ch < 3; ch++) begin
      relu[ch]   = pix[ch][CONV_BIT-1] ? '0 : pix[ch][PW-1:0];
      hmax[ch]   = (relu[ch] > hold_q[ch]) ? relu[ch] : hold_q[ch];
      pooled[ch] = (lb_q[ch][lb_idx] > hmax[ch]) ? lb_q[ch][lb_idx] : hmax[ch];
      if (32'(pooled[ch]) > SatMax) sat[ch] = SatMax[OUT_BIT-1:0];
      else                          sat[ch] = OUT_BIT'(pooled[ch]);
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        hold_q[ch] <= '0;
        out_q[ch]  <= '0;
        for (int k = 0; k < int'(HalfSize); k++) lb_q[ch][k] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_in && col_q[0] && row_q[0];
      done_q  <= valid_in && last_col && last_row;
      if (valid_in) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (!col_q[0])      hold_q[ch]         <= relu[ch];
          else if (!row_q[0]) lb_q[ch][lb_idx]   <= hmax[ch];
          else                out_q[ch]          <= sat[ch];
        end
      end
    end
  end

  assign max_value_1 = out_q[0];
  assign max_value_2 = out_q[1];
  assign max_value_3 = out_q[2];
  assign valid_out   = valid_q;
  assign frame_done  = done_q;

endmodule

// File: doc/maxpool2_relu.md
MAXPOOL2_RELU -- requirements
Module: maxpool2_relu

Interface
REQ-001 SHALL have parameter CONV_BIT, default 14, width of each signed input pixel.
REQ-002 SHALL have parameter OUT_BIT, default 12, width of each signed output value.
REQ-003 SHALL have parameter IN_SIZE, default 8, input feature-map width and height in pixels (even).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port valid_in  input  1  qualifies one input pixel per channel in this cycle.
REQ-007 SHALL have ports conv_out_1, conv_out_2, conv_out_3  input  CONV_BIT signed  conv2 results for channels 1-3.
REQ-008 SHALL have ports max_value_1, max_value_2, max_value_3  output  OUT_BIT signed  pooled, ReLU'd, saturated results.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse qualifying max_value_1..3.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-011 SHALL treat input as IN_SIZE x IN_SIZE map per channel, row-major, one pixel per valid_in cycle; gaps of any length allowed.
REQ-012 SHALL track position with column counter (0..IN_SIZE-1) and row counter (0..IN_SIZE-1), advanced only on valid_in.
REQ-013 SHALL wrap column to 0 and increment row after column IN_SIZE-1; after (row IN_SIZE-1, column IN_SIZE-1) both SHALL wrap to 0 for the next frame.
REQ-014 SHALL apply ReLU to each accepted pixel: negative -> 0, else unchanged.
REQ-015 On even column, SHALL hold ReLU'd pixel per channel in a hold register.
REQ-016 On odd column, SHALL form horizontal max = max(hold, current ReLU'd pixel) per channel.
REQ-017 On even row, odd column, SHALL write horizontal max into line-buffer entry column>>1 (IN_SIZE/2 entries per channel, CONV_BIT-1 bits unsigned).
REQ-018 On odd row, odd column, SHALL compute pooled = max(line-buffer[column>>1], horizontal max) per channel.
REQ-019 SHALL saturate pooled to 2^(OUT_BIT-1)-1 (2047 at default) when larger, else pass unchanged; output always >= 0.
REQ-020 SHALL register saturated results to max_value_1..3 and assert valid_out on the clock edge after the accepting edge of each odd-row, odd-column pixel (latency 1 cycle).
REQ-021 valid_out SHALL be high exactly one cycle per pooled result: (IN_SIZE/2)^2 pulses per frame, 16 at default.
REQ-022 max_value_1..3 SHALL hold last value while valid_out is low.
REQ-023 frame_done SHALL pulse with the valid_out produced by pixel (IN_SIZE-1, IN_SIZE-1), and at no other time.
REQ-024 SHALL accept a new pixel in the same cycle valid_out is high; no backpressure, no stall.
REQ-025 Line-buffer entry SHALL be overwritten by next even row before reuse; no clearing between frames required.

Reset
REQ-026 On rst_n low, SHALL immediately clear counters, hold registers, line buffer, max_value_1..3, valid_out, frame_done to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; first valid_in after release SHALL be pixel (0,0).
REQ-028 valid_in while rst_n low SHALL be ignored.

Verification
REQ-029 All 3 channels constant 100, 64 back-to-back pixels -> 16 valid_out pulses of 100 each, 1 cycle after pixels 9,11,13,15,25,...,63 (0-based), frame_done with 16th.
REQ-030 All pixels -5 -> 16 outputs of 0 on every channel.
REQ-031 Channel 1 pixel = row*8+col -> output (i,j) = (2i+1)*8+(2j+1), i.e. 9,11,13,15,25,...,63; channels 2/3 = 0 -> 0.
REQ-032 Channel 2 pixels 8191 -> all outputs 2047; single pixel 3000 in window, rest 0 -> that window 2047.
REQ-033 Random 0-5 idle cycles between valid_in, random values -> outputs and order identical to back-to-back run, each 1 cycle after its closing pixel.
REQ-034 rst_n low for 1 cycle after 20 pixels, then full frame of constant 7 -> no output before new frame, exactly 16 outputs of 7, one frame_done.
